// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   ADDR_W_DEFAULT : default address width
//   DATA_W_DEFAULT : default data width
//   RELEASE_LEN    : number of cycles the RELEASE state lasts
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned RELEASE_LEN    = 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        FETCH_WAIT = 2'd2,
        RELEASE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ibuf_entry.sv
// ibuf_entry
// One-entry instruction fetch buffer holding {valid, addr, instr}.
// Only compiled when ARB_INST_BUF_EN is defined; otherwise this file is empty.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset (clears valid)
//   i_fill          : load entry with i_fill_adr / i_fill_instr and set valid
//   i_inval         : a write is being issued to i_inval_adr
//   i_inval_adr     : address of that write; a match clears valid
//   i_lookup_adr    : fetch address to compare against the entry
//   o_hit           : entry valid and address matches
//   o_instr         : buffered instruction
`ifdef ARB_INST_BUF_EN
module ibuf_entry #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_adr,
    input  logic [DATA_W-1:0] i_fill_instr,
    input  logic              i_inval,
    input  logic [ADDR_W-1:0] i_inval_adr,
    input  logic [ADDR_W-1:0] i_lookup_adr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_instr
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_instr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_instr <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_adr;
            r_instr <= i_fill_instr;
        end else if (i_inval && (i_inval_adr == r_addr)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit   = r_valid && (i_lookup_adr == r_addr);
    assign o_instr = r_instr;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and data access.
// Data accesses win over fetch (they belong to the older instruction); the
// pipeline is frozen via o_stall until both requests have been serviced.
// Optional one-entry fetch buffer: define ARB_INST_BUF_EN.
// Ports:
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_inst_adr, i_inst_req     : fetch request from the PC
//   o_inst, o_inst_valid       : registered fetched instruction and its strobe
//   i_data_adr, i_mem_read,
//   i_mem_write, i_data_out    : data access request from EX/MEM
//   o_data_in, o_data_done     : registered load data and completion strobe
//   o_stall                    : freezes PC and pipeline registers
//   o_mem_adr, o_mem_wdata,
//   o_mem_rd, o_mem_wr         : registered memory command
//   i_mem_rdata, i_mem_ready   : memory response
//   o_protocol_err             : sticky, read and write requested together
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_inst_adr,
    input  logic              i_inst_req,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_inst_valid,
    input  logic [ADDR_W-1:0] i_data_adr,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [DATA_W-1:0] i_data_out,
    output logic [DATA_W-1:0] o_data_in,
    output logic              o_data_done,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_mem_adr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_protocol_err
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] r_data_in;
    logic              r_inst_valid;
    logic              r_data_done;
    logic              r_protocol_err;
    logic              r_svc_fetch;
    logic              r_svc_data;
    logic [1:0]        r_rel_cnt;

    logic              w_data_req;
    logic              w_rel_last;
    logic              w_issue_data;
    logic              w_issue_fetch;
    logic              w_data_cpl;
    logic              w_fetch_cpl;
    logic              w_buf_use;
    logic              w_buf_inval;
    logic              w_buf_hit;
    logic [DATA_W-1:0] w_buf_instr;

    assign w_data_req = i_mem_read || i_mem_write;
    assign w_rel_last = (r_rel_cnt == 2'(RELEASE_LEN - 1));

`ifdef ARB_INST_BUF_EN
    assign w_buf_inval = w_issue_data && i_mem_write;

    ibuf_entry #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fill       (w_fetch_cpl),
        .i_fill_adr   (r_mem_adr),
        .i_fill_instr (i_mem_rdata),
        .i_inval      (w_buf_inval),
        .i_inval_adr  (i_data_adr),
        .i_lookup_adr (i_inst_adr),
        .o_hit        (w_buf_hit),
        .o_instr      (w_buf_instr)
    );
`else
    assign w_buf_inval = 1'b0;
    assign w_buf_hit   = 1'b0;
    assign w_buf_instr = '0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; mem_ready only matters in the WAIT states
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_data_req) begin
                    w_state_next = DATA_WAIT;
                end else if (i_inst_req) begin
                    w_state_next = w_buf_hit ? RELEASE : FETCH_WAIT;
                end
            end
            DATA_WAIT: begin
                if (i_mem_ready) begin
                    w_state_next = (i_inst_req && !w_buf_hit) ? FETCH_WAIT : RELEASE;
                end
            end
            FETCH_WAIT: begin
                if (i_mem_ready) begin
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (w_rel_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        w_issue_data  = 1'b0;
        w_issue_fetch = 1'b0;
        w_data_cpl    = 1'b0;
        w_fetch_cpl   = 1'b0;
        w_buf_use     = 1'b0;
        o_stall       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_issue_data  = w_data_req;
                w_issue_fetch = !w_data_req && i_inst_req && !w_buf_hit;
                w_buf_use     = !w_data_req && i_inst_req && w_buf_hit;
                o_stall       = w_data_req || i_inst_req;
            end
            DATA_WAIT: begin
                w_data_cpl    = i_mem_ready;
                w_issue_fetch = i_mem_ready && i_inst_req && !w_buf_hit;
                w_buf_use     = i_mem_ready && i_inst_req && w_buf_hit;
                o_stall       = 1'b1;
            end
            FETCH_WAIT: begin
                w_fetch_cpl = i_mem_ready;
                o_stall     = 1'b1;
            end
            RELEASE: begin
                o_stall = 1'b0;
            end
            default: o_stall = 1'b0;
        endcase
    end

    // Datapath registers: memory command, captured data and release strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_adr      <= '0;
            r_mem_wdata    <= '0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_inst         <= '0;
            r_data_in      <= '0;
            r_inst_valid   <= 1'b0;
            r_data_done    <= 1'b0;
            r_protocol_err <= 1'b0;
            r_svc_fetch    <= 1'b0;
            r_svc_data     <= 1'b0;
            r_rel_cnt      <= '0;
        end else begin
            if (w_issue_data) begin
                r_mem_adr   <= i_data_adr;
                r_mem_wdata <= i_data_out;
                // A read+write conflict is executed as a write
                r_mem_wr    <= i_mem_write;
                r_mem_rd    <= i_mem_read && !i_mem_write;
            end else if (w_issue_fetch) begin
                r_mem_adr <= i_inst_adr;
                r_mem_rd  <= 1'b1;
                r_mem_wr  <= 1'b0;
            end else if (w_data_cpl || w_fetch_cpl) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
            end

            if (w_issue_data && i_mem_read && i_mem_write) begin
                r_protocol_err <= 1'b1;
            end

            // Stores leave data_in untouched
            if (w_data_cpl && r_mem_rd) begin
                r_data_in <= i_mem_rdata;
            end

            if (w_fetch_cpl) begin
                r_inst <= i_mem_rdata;
            end else if (w_buf_use) begin
                r_inst <= w_buf_instr;
            end

            if (r_state == RELEASE && w_state_next == IDLE) begin
                r_svc_fetch <= 1'b0;
                r_svc_data  <= 1'b0;
            end else begin
                if (w_issue_data) begin
                    r_svc_data <= 1'b1;
                end
                if (w_fetch_cpl || w_buf_use) begin
                    r_svc_fetch <= 1'b1;
                end
            end

            r_inst_valid <= (w_state_next == RELEASE) &&
                            (r_svc_fetch || w_fetch_cpl || w_buf_use);
            r_data_done  <= (w_state_next == RELEASE) && (r_svc_data || w_data_cpl);

            if (r_state == RELEASE && !w_rel_last) begin
                r_rel_cnt <= r_rel_cnt + 2'd1;
            end else begin
                r_rel_cnt <= '0;
            end
        end
    end

    assign o_mem_adr      = r_mem_adr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_mem_rd       = r_mem_rd;
    assign o_mem_wr       = r_mem_wr;
    assign o_inst         = r_inst;
    assign o_data_in      = r_data_in;
    assign o_inst_valid   = r_inst_valid;
    assign o_data_done    = r_data_done;
    assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scoreboard bench: stimulus pushes expected release responses and memory
// commands into queues; a monitor pops and compares when the DUT presents them.
// Build with ARB_INST_BUF_EN defined to exercise the fetch buffer.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        iv;
        logic        dd;
        logic [31:0] inst;
        logic [31:0] din;
    } rsp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst_adr;
    logic        inst_req;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] data_adr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        data_done;
    logic        stall;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        protocol_err;

    rsp_t rsp_q[$];
    cmd_t cmd_q[$];
    int   checks = 0;
    int   passes = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_inst_adr     (inst_adr),
        .i_inst_req     (inst_req),
        .o_inst         (inst),
        .o_inst_valid   (inst_valid),
        .i_data_adr     (data_adr),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_data_out     (data_out),
        .o_data_in      (data_in),
        .o_data_done    (data_done),
        .o_stall        (stall),
        .o_mem_adr      (mem_adr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_rd       (mem_rd),
        .o_mem_wr       (mem_wr),
        .i_mem_rdata    (mem_rdata),
        .i_mem_ready    (mem_ready),
        .o_protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h2008_0005;
            32'h04:  return 32'h1111_2222;
            32'h08:  return 32'h8C09_0010;
            32'h10:  return 32'hDEAD_BEEF;
            32'h14:  return 32'hCAFE_F00D;
            default: return 32'h9999_9999;
        endcase
    endfunction

    assign mem_rdata = mem_model(mem_adr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid || data_done) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, inst_valid, data_done}, 32'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_inst_valid", {31'd0, inst_valid}, {31'd0, e.iv});
                    chk("rsp_data_done", {31'd0, data_done}, {31'd0, e.dd});
                    chk("rsp_inst", inst, e.inst);
                    chk("rsp_data_in", data_in, e.din);
                end
            end
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {30'd0, mem_rd, mem_wr}, 32'd0);
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    chk("cmd_rd", {31'd0, mem_rd}, {31'd0, c.rd});
                    chk("cmd_wr", {31'd0, mem_wr}, {31'd0, c.wr});
                    chk("cmd_adr", mem_adr, c.adr);
                    if (c.wr) chk("cmd_wdata", mem_wdata, c.wdata);
                end
            end
        end
    end

    task automatic clear_inputs();
        inst_req  = 1'b0;
        inst_adr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        data_adr  = '0;
        data_out  = '0;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE
    task automatic go(input string nm, input logic rd, input logic wr, input logic req,
                      input logic [31:0] dadr, input logic [31:0] dout,
                      input logic [31:0] iadr, input int exp_stalls);
        int  n;
        bit  done;
        mem_read  = rd;
        mem_write = wr;
        inst_req  = req;
        data_adr  = dadr;
        data_out  = dout;
        inst_adr  = iadr;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
        end
        chk(nm, n, exp_stalls);
        @(posedge clk);
        #1 clear_inputs();
    endtask

    initial begin
        clear_inputs();
        mem_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_inst", inst, 32'h0);
        chk("rst_data_in", data_in, 32'h0);
        chk("rst_strobes", {28'd0, inst_valid, data_done, mem_rd, mem_wr}, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_perr_stall", {30'd0, protocol_err, stall}, 32'h0);
        @(posedge clk);
        #1;

        // Fetch only: stall 1,1,0
        rsp_q.push_back('{iv: 1'b1, dd: 1'b0, inst: 32'h2008_0005, din: 32'h0});
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h0, wdata: 32'h0});
        go("fetch_stalls", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 2);

        // Load plus fetch: data first, then fetch, one combined release
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h10, wdata: 32'h0});
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h8, wdata: 32'h0});
        rsp_q.push_back('{iv: 1'b1, dd: 1'b1, inst: 32'h8C09_0010, din: 32'hDEAD_BEEF});
        go("load_fetch_stalls", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'h8, 3);

        // Slow memory: 4 cycles of mem_ready low in DATA_WAIT
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h14, wdata: 32'h0});
        rsp_q.push_back('{iv: 1'b0, dd: 1'b1, inst: 32'h8C09_0010, din: 32'hCAFE_F00D});
        mem_ready = 1'b0;
        mem_read  = 1'b1;
        data_adr  = 32'h14;
        @(negedge clk);
        chk("slow_idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slow_hold_adr", mem_adr, 32'h14);
            chk("slow_hold_rd_stall", {30'd0, mem_rd, stall}, 32'd3);
            @(posedge clk);
        end
        #1 mem_ready = 1'b1;
        @(negedge clk);
        chk("slow_last_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("slow_release_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 clear_inputs();

        // Read/write conflict executes as a write; data_in keeps its value
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, adr: 32'h20, wdata: 32'h5});
        rsp_q.push_back('{iv: 1'b0, dd: 1'b1, inst: 32'h8C09_0010, din: 32'hCAFE_F00D});
        go("conflict_stalls", 1'b1, 1'b1, 1'b0, 32'h20, 32'h5, 32'h0, 2);
        @(negedge clk);
        chk("conflict_perr", {31'd0, protocol_err}, 32'd1);
        @(posedge clk);
        #1;

        // Fetch buffer: repeat fetch of 0x4, then a store to 0x4 invalidates
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h4, wdata: 32'h0});
        rsp_q.push_back('{iv: 1'b1, dd: 1'b0, inst: 32'h1111_2222, din: 32'hCAFE_F00D});
        go("buf_first_stalls", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 2);
        rsp_q.push_back('{iv: 1'b1, dd: 1'b0, inst: 32'h1111_2222, din: 32'hCAFE_F00D});
`ifdef ARB_INST_BUF_EN
        go("buf_hit_stalls", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 1);
`else
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h4, wdata: 32'h0});
        go("nobuf_refetch_stalls", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 2);
`endif
        cmd_q.push_back('{rd: 1'b0, wr: 1'b1, adr: 32'h4, wdata: 32'h77});
        rsp_q.push_back('{iv: 1'b0, dd: 1'b1, inst: 32'h1111_2222, din: 32'hCAFE_F00D});
        go("store_stalls", 1'b0, 1'b1, 1'b0, 32'h4, 32'h77, 32'h0, 2);
        cmd_q.push_back('{rd: 1'b1, wr: 1'b0, adr: 32'h4, wdata: 32'h0});
        rsp_q.push_back('{iv: 1'b1, dd: 1'b0, inst: 32'h1111_2222, din: 32'hCAFE_F00D});
        go("refetch_after_store", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 2);
        @(negedge clk);
        chk("perr_sticky", {31'd0, protocol_err}, 32'd1);
        @(posedge clk);
        #1;

        // Reset during FETCH_WAIT aborts the access
        mem_ready = 1'b0;
        inst_req  = 1'b1;
        inst_adr  = 32'h0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_rd", {31'd0, mem_rd}, 32'd1);
        rst      = 1'b1;
        inst_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("abort_inst", inst, 32'h0);
        chk("abort_data_in", data_in, 32'h0);
        chk("abort_perr_stall", {30'd0, protocol_err, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_valid", {31'd0, inst_valid}, 32'd0);
        end

        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("cmd_q_drained", cmd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
